// File: rtl/mux_pkg.sv
// Shared definitions for the N-input registered selector.
//   MODE_SEL / MODE_RR : values of the mode input.
//   sel_w()            : width of a channel index for a given channel count.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // A 1-channel mux still needs a 1-bit index port.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter. The search starts at ptr and wraps modulo NUM_IN,
// so the requester at ptr has highest priority and the one at ptr-1 has the lowest.
//   req       : per-channel request
//   ptr       : index with highest priority this cycle (must be < NUM_IN)
//   grant     : one-hot grant, zero when nothing requests
//   grant_idx : index of the granted channel (0 when no grant)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [2*NUM_IN-1:0] req_dbl;
  logic [NUM_IN-1:0]   req_rot;
  logic [SEL_W:0]      idx_sum;
  logic                found;

  // Rotate requests so that bit 0 corresponds to channel ptr.
  assign req_dbl = {req, req};
  assign req_rot = NUM_IN'(req_dbl >> ptr);

  always_comb begin
    found     = 1'b0;
    idx_sum   = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        idx_sum = {1'b0, ptr} + (SEL_W+1)'(i);
        if (int'(idx_sum) >= NUM_IN)
          idx_sum = idx_sum - (SEL_W+1)'(NUM_IN);
        grant_idx = idx_sum[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int k = 0; k < NUM_IN; k++)
      grant[k] = found && (int'(grant_idx) == k);
  end

endmodule

// File: rtl/mux_nw_rr_pipe.sv
// N-input, WIDTH-bit selector with a single registered output stage.
// mode=MODE_SEL picks channel sel; mode=MODE_RR arbitrates round-robin.
//   clk, reset          : clock, synchronous active-high reset
//   mode, sel           : selection mode and explicit channel index
//   in_valid, in_ready  : per-channel handshake (in_ready one-hot or zero)
//   in_data             : channel k at [k*WIDTH +: WIDTH]
//   out_valid, out_ready: output handshake
//   out_data, out_src   : registered data and the channel it came from
module mux_nw_rr_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src
);

  localparam int STAGES = 1;

  logic [NUM_IN-1:0][WIDTH-1:0] lanes;
  logic [NUM_IN-1:0][WIDTH-1:0] lanes_masked;
  logic [NUM_IN-1:0]            sel_grant;
  logic [NUM_IN-1:0]            rr_grant;
  logic [NUM_IN-1:0]            grant;
  logic [SEL_W-1:0]             rr_idx;
  logic [SEL_W-1:0]             src_idx;
  logic [SEL_W-1:0]             ptr;
  logic [WIDTH-1:0]             mux_data;
  logic                         can_load;
  // vld_pipe[0] is the accept strobe, vld_pipe[STAGES] the output register valid.
  logic [STAGES:0]              vld_pipe;

  assign lanes = in_data;

  // Explicit select; an out-of-range sel matches no channel and grants nothing.
  always_comb begin
    sel_grant = '0;
    for (int k = 0; k < NUM_IN; k++)
      sel_grant[k] = in_valid[k] && (int'(sel) == k);
  end

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  assign grant   = (mode == MODE_RR) ? rr_grant : sel_grant;
  assign src_idx = (mode == MODE_RR) ? rr_idx   : sel;

  assign can_load = !vld_pipe[STAGES] || out_ready;
  // Held low during reset so nothing looks accepted on an edge that reset discards.
  assign in_ready = (can_load && !reset) ? grant : '0;

  assign vld_pipe[0] = |in_ready;

  // AND-OR one-hot select: ungranted lanes are forced to zero, so their
  // contents (including X) never reach out_data.
  genvar g;
  generate
    for (g = 0; g < NUM_IN; g++) begin : g_mask
      assign lanes_masked[g] = lanes[g] & {WIDTH{grant[g]}};
    end
  endgenerate

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++)
      mux_data = mux_data | lanes_masked[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[STAGES] <= 1'b0;
      out_data         <= '0;
      out_src          <= '0;
      ptr              <= '0;
    end else if (vld_pipe[0]) begin
      vld_pipe[STAGES] <= 1'b1;
      out_data         <= mux_data;
      out_src          <= src_idx;
      if (mode == MODE_RR)
        ptr <= (int'(src_idx) == NUM_IN-1) ? '0 : src_idx + SEL_W'(1);
    end else if (out_ready) begin
      // Drained with nothing to replace it.
      vld_pipe[STAGES] <= 1'b0;
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: doc/mux_nw_rr_pipe.md
Name: mux_nw_rr_pipe

Overview:
- Parametrised N-input, W-bit selector with one registered output stage and valid/ready handshake on every port.
- Supports explicit-select mode and round-robin arbitration mode.
- Sits between multiple datapath producers (ALU result, memory read data, PC+4, immediate) and a single consumer stage.
- Replaces ad-hoc chains of fixed-width 2:1 muxes in the datapath.

Parameters:
- WIDTH, 64, data bits per channel.
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_IN), derived select/source-index width; not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  channel index, used only when mode=0.
- in_valid  in  NUM_IN  per-channel valid.
- in_data  in  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  out  NUM_IN  per-channel ready (one-hot or zero).
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts output.
- out_data  out  WIDTH  registered selected data.
- out_src  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (reset=1 at a clk edge): out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. Reset overrides any concurrent transfer.
- Two-state control:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = EMPTY, or FULL with out_ready=1.
- Grant, combinational, at most one bit:
  - mode=0: grant[sel]=in_valid[sel]; no grant if sel >= NUM_IN.
  - mode=1: grant the first k with in_valid[k]=1, searching ptr, ptr+1, ... NUM_IN-1, 0, ... ptr-1 (modulo wrap).
- in_ready = grant when can_load=1, else all zeros. in_ready never depends on out_valid of the same cycle except through can_load.
- A transfer occurs on channel k when in_valid[k] & in_ready[k]. On that edge: out_data <= channel k data, out_src <= k, out_valid <= 1.
- Latency is exactly 1 cycle, input acceptance to out_valid.
- Throughput is one word per cycle when out_ready is held high.
- FULL and out_ready=1 with no grant: out_valid <= 0 (go EMPTY).
- FULL and out_ready=0: out_data and out_src hold, and all in_ready are 0.
- Pointer updates only in mode=1 and only on a transfer: ptr <= (k == NUM_IN-1) ? 0 : k+1. In mode=0, ptr holds.
- Mode or sel change while FULL: registered data unaffected; the new mode applies to the next grant only.
- No valid inputs while EMPTY: remain EMPTY, in_ready all zeros.
- in_data on non-granted channels is ignored. X on an unselected channel must not propagate to out_data.

Decomposition:
- Shared package mux_pkg:
  - mode constants MODE_SEL=1'b0 and MODE_RR=1'b1.
  - a function deriving SEL_W from NUM_IN.
- One sub-module, rr_arbiter (parameter NUM_IN): inputs req[NUM_IN] and ptr; outputs grant one-hot and grant_idx.
- Data selection uses an AND-OR one-hot structure on grant, consistent with the existing gate-level muxes.

Test Plan (NUM_IN=4, WIDTH=64):
- Reset: assert reset for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=4'b0000 during reset; first grant afterwards in mode=1 goes to channel 0.
- Explicit mode: mode=0, sel=2, in_valid=4'b0100, ch2 data=64'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=64'hDEAD_BEEF, out_src=2.
- Backpressure: FULL with out_ready=0 for 3 cycles while ch1 valid -> out_data stable, in_ready=0. Release out_ready -> ch1 accepted on that edge and appears the following cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3.
- Wrap with gaps: mode=1, ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2. Then in_valid=4'b1001 -> grant ch3, ptr wraps to 0.
- Invalid select and mid-operation reset: mode=0, sel=3, in_valid=4'b0111 -> no grant, stays EMPTY. Assert reset while FULL with out_ready=0 -> out_valid=0 next edge.
